// File: rtl/imem_stream_loader_if.sv
// Fetch port and byte-stream loader bundle for imem_stream_loader.
// master = CPU/host side, slave = the memory.
interface imem_stream_loader_if #(
    parameter int ADDR_W = 30
);
    logic [ADDR_W-1:0] addr;
    logic              stall;
    logic [31:0]       inst;
    logic              load_start;
    logic [15:0]       load_words;
    logic              ld_valid;
    logic [7:0]        ld_byte;
    logic              ld_ready;
    logic              loading;
    logic              load_done;
    logic              load_err;
    logic [15:0]       load_count;

    modport master (
        output addr, stall, load_start, load_words, ld_valid, ld_byte,
        input  inst, ld_ready, loading, load_done, load_err, load_count
    );

    modport slave (
        input  addr, stall, load_start, load_words, ld_valid, ld_byte,
        output inst, ld_ready, loading, load_done, load_err, load_count
    );
endinterface

// File: rtl/imem_stream_loader.sv
// Instruction memory with registered-address fetch port and a
// runtime byte-stream loader (IDLE -> RECV -> DONE).
module imem_stream_loader #(
    parameter int          ADDR_W       = 30,
    parameter int          DEPTH        = 1024,
    parameter bit          BIG_ENDIAN   = 1'b1,
    parameter logic [31:0] DEFAULT_INST = 32'h0000_0000
) (
    input  logic                clk,
    input  logic                rst_n,
    imem_stream_loader_if.slave bus
);
    localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, RECV, DONE} state_t;

    logic [31:0] mem [DEPTH];

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       wptr_q, wptr_d;
    logic [15:0]       count_q, count_d;
    logic [15:0]       eff_len_q, eff_len_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [23:0]       hold_q, hold_d;
    logic              err_q, err_d;

    logic        xfer;
    logic        we;
    logic        over;
    logic        in_range;
    logic [31:0] wdata;

    // Full-width compare so high address bits never alias into the array.
    assign in_range = 64'(addr_q) < 64'(DEPTH);
    assign over     = 32'(bus.load_words) > 32'(DEPTH);
    assign xfer     = bus.ld_valid && (state_q == RECV);
    assign wdata    = BIG_ENDIAN ? {hold_q, bus.ld_byte}
                                 : {bus.ld_byte, hold_q};

    always_comb begin
        addr_d = bus.stall ? addr_q : bus.addr;
    end

    always_comb begin
        state_d    = state_q;
        wptr_d     = wptr_q;
        count_d    = count_q;
        eff_len_d  = eff_len_q;
        byte_cnt_d = byte_cnt_q;
        hold_d     = hold_q;
        err_d      = err_q;
        we         = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.load_start) begin
                    wptr_d     = '0;
                    byte_cnt_d = '0;
                    count_d    = '0;
                    err_d      = over;
                    eff_len_d  = over ? 16'(DEPTH) : bus.load_words;
                    state_d    = (bus.load_words == '0) ? DONE : RECV;
                end
            end
            RECV: begin
                if (xfer) begin
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    hold_d     = BIG_ENDIAN ? {hold_q[15:0], bus.ld_byte}
                                            : {bus.ld_byte, hold_q[23:8]};
                    if (byte_cnt_q == 2'd3) begin
                        we      = 1'b1;
                        wptr_d  = wptr_q + 16'd1;
                        count_d = count_q + 16'd1;
                        if (count_d == eff_len_q) begin
                            state_d = DONE;
                        end
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            wptr_q     <= '0;
            count_q    <= '0;
            eff_len_q  <= '0;
            byte_cnt_q <= '0;
            hold_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wptr_q     <= wptr_d;
            count_q    <= count_d;
            eff_len_q  <= eff_len_d;
            byte_cnt_q <= byte_cnt_d;
            hold_q     <= hold_d;
            err_q      <= err_d;
        end
    end

    // Array has no reset so contents survive a reset-aborted load.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wptr_q[MEM_AW-1:0]] <= wdata;
        end
    end

    assign bus.inst       = ((state_q == RECV) || !in_range) ? DEFAULT_INST
                                                             : mem[addr_q[MEM_AW-1:0]];
    assign bus.ld_ready   = (state_q == RECV);
    assign bus.loading    = (state_q == RECV);
    assign bus.load_done  = (state_q == DONE);
    assign bus.load_err   = err_q;
    assign bus.load_count = count_q;
endmodule

// File: tb/tb_imem_stream_loader.sv
// Bench for imem_stream_loader: big/little-endian 1024-word parts
// and a 4-word part, checked against a byte-order reference model.
module tb_imem_stream_loader;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int          sel;
  logic        s_start;
  logic [15:0] s_words;
  logic        s_valid;
  logic [7:0]  s_byte;
  logic [29:0] s_addr;
  logic        s_stall;

  imem_stream_loader_if #(.ADDR_W(30)) if_be ();
  imem_stream_loader_if #(.ADDR_W(30)) if_le ();
  imem_stream_loader_if #(.ADDR_W(30)) if_sm ();

  assign if_be.addr       = s_addr;
  assign if_be.stall      = s_stall;
  assign if_be.load_start = (sel == 0) ? s_start : 1'b0;
  assign if_be.load_words = s_words;
  assign if_be.ld_valid   = (sel == 0) ? s_valid : 1'b0;
  assign if_be.ld_byte    = s_byte;

  assign if_le.addr       = s_addr;
  assign if_le.stall      = s_stall;
  assign if_le.load_start = if_be.load_start;
  assign if_le.load_words = s_words;
  assign if_le.ld_valid   = if_be.ld_valid;
  assign if_le.ld_byte    = s_byte;

  assign if_sm.addr       = s_addr;
  assign if_sm.stall      = s_stall;
  assign if_sm.load_start = (sel == 1) ? s_start : 1'b0;
  assign if_sm.load_words = s_words;
  assign if_sm.ld_valid   = (sel == 1) ? s_valid : 1'b0;
  assign if_sm.ld_byte    = s_byte;

  imem_stream_loader #(.ADDR_W(30), .DEPTH(1024), .BIG_ENDIAN(1'b1))
    u_be (.clk(clk), .rst_n(rst_n), .bus(if_be.slave));
  imem_stream_loader #(.ADDR_W(30), .DEPTH(1024), .BIG_ENDIAN(1'b0))
    u_le (.clk(clk), .rst_n(rst_n), .bus(if_le.slave));
  imem_stream_loader #(.ADDR_W(30), .DEPTH(4), .BIG_ENDIAN(1'b1))
    u_sm (.clk(clk), .rst_n(rst_n), .bus(if_sm.slave));

  logic        r_ready, r_done, r_loading;
  logic [31:0] r_inst;
  assign r_ready   = (sel == 1) ? if_sm.ld_ready : if_be.ld_ready;
  assign r_done    = (sel == 1) ? if_sm.load_done : if_be.load_done;
  assign r_loading = (sel == 1) ? if_sm.loading : if_be.loading;
  assign r_inst    = (sel == 1) ? if_sm.inst : if_be.inst;

  int n_assert = 0;
  int n_fail   = 0;

  logic [7:0]  bq [$];
  logic [31:0] mdl_be [0:1023];
  logic [31:0] mdl_le [0:1023];
  logic [31:0] mdl_sm [0:3];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_rdy"},  32'(if_be.ld_ready),   32'd0);
    chk({tag, "_ldg"},  32'(if_be.loading),    32'd0);
    chk({tag, "_done"}, 32'(if_be.load_done),  32'd0);
    chk({tag, "_err"},  32'(if_be.load_err),   32'd0);
    chk({tag, "_cnt"},  32'(if_be.load_count), 32'd0);
    chk({tag, "_sm_rdy"}, 32'(if_sm.ld_ready),   32'd0);
    chk({tag, "_sm_cnt"}, 32'(if_sm.load_count), 32'd0);
  endtask

  // Reference: byte b[4w+k] is k-th byte of word w.
  task automatic commit(input int tgt, input int nw);
    for (int w = 0; w < nw; w++) begin
      logic [7:0] b0, b1, b2, b3;
      b0 = bq[4*w]; b1 = bq[4*w+1]; b2 = bq[4*w+2]; b3 = bq[4*w+3];
      if (tgt == 0) begin
        mdl_be[w] = {b0, b1, b2, b3};
        mdl_le[w] = {b3, b2, b1, b0};
      end else begin
        mdl_sm[w] = {b0, b1, b2, b3};
      end
    end
  endtask

  task automatic fetch(input logic [29:0] a);
    s_addr = a;
    @(negedge clk);
  endtask

  task automatic do_load(input int tgt, input int nwords, input int nbytes,
                         input bit gap, input bit mid_start,
                         input int abort_at, output int rdy,
                         output int done_cyc, output int acc);
    int cyc;
    bit phase;
    sel = tgt;
    s_words = 16'(nwords);
    s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    cyc = 0; rdy = 0; done_cyc = -1; acc = 0; phase = 1'b0;
    while (cyc < 400) begin
      cyc++;
      if (abort_at >= 0 && acc == abort_at) begin
        rst_n = 1'b0;
        s_valid = 1'b0;
        #1;
        chk_reset("abort");
        return;
      end
      if (r_done) begin
        done_cyc = cyc;
        break;
      end
      if (r_ready) rdy++;
      if (cyc == 1 && tgt == 0 && nwords > 0) begin
        chk("loading_flag", 32'(r_loading), 32'd1);
        chk("inst_while_loading", r_inst, 32'h0);
      end
      s_start = (mid_start && cyc == 3);
      if (mid_start && cyc == 3) s_words = 16'd1;
      if (r_ready && acc < nbytes && (!gap || !phase)) begin
        s_valid = 1'b1;
        s_byte = bq[acc];
        acc++;
      end else begin
        s_valid = 1'b0;
      end
      phase = ~phase;
      @(negedge clk);
    end
    s_valid = 1'b0;
    s_start = 1'b0;
    chk("load_timeout", 32'(done_cyc < 0), 32'd0);
    @(negedge clk);
    chk("done_one_cycle", 32'(r_done), 32'd0);
    chk("ready_after_done", 32'(r_ready), 32'd0);
  endtask

  int rdy, dc, acc, n;
  bit g;
  logic [29:0] big;

  initial begin
    rst_n = 1'b0;
    sel = 0; s_start = 0; s_words = 0; s_valid = 0;
    s_byte = 0; s_addr = 0; s_stall = 0;
    repeat (2) @(negedge clk);
    chk_reset("reset");
    rst_n = 1'b1;
    @(negedge clk);

    bq = '{8'h24, 8'h09, 8'hFF, 8'hFF, 8'h40, 8'h89, 8'h60, 8'h00};
    do_load(0, 2, 8, 1'b0, 1'b0, -1, rdy, dc, acc);
    chk("dir_rdy_cycles", 32'(rdy), 32'd8);
    chk("dir_done_cyc", 32'(dc), 32'd9);
    chk("dir_count", 32'(if_be.load_count), 32'd2);
    chk("dir_err", 32'(if_be.load_err), 32'd0);
    commit(0, 2);
    fetch(30'd0);
    chk("be_w0", if_be.inst, 32'h2409FFFF);
    chk("le_w0", if_le.inst, 32'hFFFF0924);
    fetch(30'd1);
    chk("be_w1", if_be.inst, 32'h40896000);
    chk("le_w1", if_le.inst, 32'h00608940);

    do_load(0, 2, 8, 1'b1, 1'b0, -1, rdy, dc, acc);
    chk("gap_done_cyc", 32'(dc), 32'd16);
    chk("gap_rdy_cycles", 32'(rdy), 32'd15);
    fetch(30'd0);
    chk("gap_be_w0", if_be.inst, mdl_be[0]);
    fetch(30'd1);
    chk("gap_le_w1", if_le.inst, mdl_le[1]);

    n = 6;
    g = 1'($urandom_range(0, 1));
    bq.delete();
    for (int i = 0; i < 4 * n; i++) bq.push_back(8'($urandom));
    do_load(0, n, 4 * n, g, 1'b0, -1, rdy, dc, acc);
    chk("rnd_done_cyc", 32'(dc), g ? 32'(8 * n) : 32'(4 * n + 1));
    chk("rnd_count", 32'(if_be.load_count), 32'(n));
    commit(0, n);
    for (int w = 0; w < n; w++) begin
      fetch(30'(w));
      chk("rnd_be", if_be.inst, mdl_be[w]);
      chk("rnd_le", if_le.inst, mdl_le[w]);
    end

    fetch(30'd0);
    s_addr = 30'd1;
    s_stall = 1'b1;
    @(negedge clk);
    chk("stall_hold", if_be.inst, mdl_be[0]);
    s_stall = 1'b0;
    @(negedge clk);
    chk("stall_release", if_be.inst, mdl_be[1]);
    fetch(30'd1024);
    chk("oor_depth", if_be.inst, 32'h0);
    big = 30'(32'd1024 + $urandom_range(0, 32'h1FFF_FFFF));
    fetch(big);
    chk("oor_big", if_be.inst, 32'h0);

    bq.delete();
    for (int i = 0; i < 24; i++) bq.push_back(8'($urandom));
    do_load(1, 6, 24, 1'b0, 1'b1, -1, rdy, dc, acc);
    chk("ovf_accepted", 32'(acc), 32'd16);
    chk("ovf_done_cyc", 32'(dc), 32'd17);
    chk("ovf_err", 32'(if_sm.load_err), 32'd1);
    chk("ovf_count", 32'(if_sm.load_count), 32'd4);
    commit(1, 4);
    for (int w = 0; w < 4; w++) begin
      fetch(30'(w));
      chk("ovf_word", if_sm.inst, mdl_sm[w]);
    end
    fetch(30'd4);
    chk("sm_oor", if_sm.inst, 32'h0);
    chk("ovf_err_held", 32'(if_sm.load_err), 32'd1);

    do_load(1, 0, 0, 1'b0, 1'b0, -1, rdy, dc, acc);
    chk("zero_done_cyc", 32'(dc), 32'd1);
    chk("zero_rdy", 32'(rdy), 32'd0);
    chk("zero_count", 32'(if_sm.load_count), 32'd0);
    chk("zero_err", 32'(if_sm.load_err), 32'd0);

    bq.delete();
    for (int i = 0; i < 12; i++) bq.push_back(8'($urandom));
    do_load(0, 3, 12, 1'b0, 1'b0, 6, rdy, dc, acc);
    commit(0, 1);
    chk("abort_keep_w0", if_be.inst, mdl_be[0]);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    fetch(30'd0);
    chk("abort_w0_after", if_be.inst, mdl_be[0]);

    bq = '{8'h24, 8'h17, 8'h00, 8'h00};
    do_load(0, 1, 4, 1'b0, 1'b0, -1, rdy, dc, acc);
    chk("reload_done_cyc", 32'(dc), 32'd5);
    chk("reload_count", 32'(if_be.load_count), 32'd1);
    commit(0, 1);
    fetch(30'd0);
    chk("reload_w0", if_be.inst, 32'h24170000);
    chk("reload_le_w0", if_le.inst, mdl_le[0]);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/imem_stream_loader.md
Name: imem_stream_loader

Overview:
- Parametrised instruction memory for the MIPS core: CPU-side word-addressed fetch port with one-cycle registered-address latency, plus a byte-stream loader that fills the memory at runtime.
- Replaces fixed, compiled-in test ROMs. A UART/host front end loads programs without re-synthesis, then releases the CPU.
- Adds fetch stall, range checking with a default instruction, and load status.

Parameters:
- ADDR_W, 30, width of the CPU word address.
- DEPTH, 1024, number of 32-bit words stored (power of two not required).
- BIG_ENDIAN, 1, 1: first streamed byte goes to inst[31:24]; 0: first byte goes to inst[7:0].
- DEFAULT_INST, 32'h00000000, value returned for out-of-range addresses and while loading (NOP).

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- addr  in  ADDR_W  CPU fetch word address
- stall  in  1  1: hold the registered fetch address
- inst  out  32  fetched instruction
- load_start  in  1  pulse; begins a load when the FSM is IDLE
- load_words  in  16  number of words to load, sampled with load_start
- ld_valid  in  1  byte-stream valid
- ld_byte  in  8  byte-stream data
- ld_ready  out  1  loader accepts a byte this cycle
- loading  out  1  FSM is in RECV
- load_done  out  1  one-cycle pulse at load completion
- load_err  out  1  sticky: load_words > DEPTH
- load_count  out  16  words written in the current or last load

Behaviour:
- Reset (rst_n=0, asynchronous):
  - addr_r=0, FSM=IDLE, ld_ready=0, loading=0, load_done=0, load_err=0, load_count=0, byte_cnt=0.
  - Memory contents are not cleared.
  - Reset mid-load aborts the load: words already written keep their values, and the partial word is discarded.
- Fetch:
  - Each edge, addr_r <= addr unless stall=1, in which case addr_r holds.
  - inst is combinational from addr_r, giving one-cycle latency from addr to inst.
  - inst = DEFAULT_INST if loading=1 or addr_r >= DEPTH; otherwise inst = mem[addr_r].
  - Reads of never-written words are undefined; the bench must load before fetching.
- Loader FSM, states IDLE, RECV, DONE:
  - IDLE:
    - ld_ready=0.
    - load_start=1 with load_words>0: go to RECV. Set wptr=0, byte_cnt=0, load_count=0, eff_len=min(load_words, DEPTH), load_err=(load_words>DEPTH).
    - load_start=1 with load_words=0: go to DONE with load_count=0 and load_err=0.
  - RECV:
    - ld_ready=1 and loading=1.
    - A byte transfers when ld_valid && ld_ready; byte_cnt increments modulo 4.
    - Bytes are assembled into a 24-bit holding register. On the 4th byte, the full word is written to mem[wptr] on that same edge, then wptr++ and load_count++.
    - If that write makes load_count == eff_len, go to DONE.
    - ld_valid=0 cycles are idle, with no timeout.
    - load_start in RECV is ignored.
  - DONE:
    - ld_ready=0 and load_done=1 for exactly one cycle, then go to IDLE.
    - A load_start arriving in DONE is ignored.
- Byte order:
  - BIG_ENDIAN=1: bytes b0..b3 form word {b0,b1,b2,b3}.
  - BIG_ENDIAN=0: bytes b0..b3 form word {b3,b2,b1,b0}.
- Overflow: with load_words > DEPTH, exactly DEPTH words are written. load_err=1 is held until the next accepted load_start or reset. Excess stream bytes are not accepted because ld_ready=0.
- Simultaneous events:
  - stall and loading are independent; addr_r keeps updating during loading.
  - The memory write in the last RECV cycle is visible to a fetch whose addr_r matches from the next cycle, once loading=0.
- Width rules: wptr and load_count are 16-bit; the addr_r >= DEPTH compare uses the full ADDR_W bits with no truncation aliasing.

Test Plan:
- Reset then load_start with load_words=2, BIG_ENDIAN=1, bytes 24,09,FF,FF,40,89,60,00 with ld_valid every cycle:
  - ld_ready=1 for 8 cycles, then load_done pulses once and load_count=2.
  - addr=0 gives inst=32'h2409FFFF the next cycle; addr=1 gives 32'h40896000.
- Same bytes with BIG_ENDIAN=0: addr=0 gives inst=32'hFFFF0924.
- ld_valid toggled 1,0,1,0 during the load: same final contents, and load_done arrives 2x later.
- Fetch addr=0, then 1 with stall=1 on the second edge: inst stays mem[0] for an extra cycle. addr=DEPTH gives 32'h00000000. inst=DEFAULT_INST while loading=1.
- DEPTH=4, load_words=6, 24 bytes offered:
  - load_err=1, load_count=4, and only 16 bytes are accepted; ld_ready=0 afterward.
  - load_start mid-RECV is ignored.
  - load_words=0 produces a load_done pulse with no ld_ready.
- Load 3 words, assert rst_n=0 after the 6th byte:
  - All outputs return to reset values immediately and word 0 is retained.
  - A new 1-word load of 0x2417_0000 succeeds.
